// File: rtl/oven_pkg.sv
// Shared types and defaults for the oven cook timer: FSM state encoding,
// default cook durations and the selection-validity check.
package oven_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUNNING,
    PAUSED,
    DONE
  } timer_state_t;

  localparam int DEF_T_SHORT = 30;
  localparam int DEF_T_MED   = 60;
  localparam int DEF_T_LONG  = 120;

  // A selection only counts when time_set is high and exactly one duration is picked.
  function automatic logic sel_valid(input logic time_set, input logic s30,
                                     input logic s60, input logic s120);
    return time_set && ({s30, s60, s120} inside {3'b100, 3'b010, 3'b001});
  endfunction

endpackage

// File: rtl/oven_prescaler.sv
// Divides clk down to one tick per counted second; the count holds while
// en is low so a paused countdown resumes mid-second.
module oven_prescaler #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/oven_cook_timer.sv
// Cook-time countdown driven by ctrl_oven: latches the selected duration,
// counts down while running, freezes while held, and pulses timeout at zero.
module oven_cook_timer
  import oven_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int CNT_W         = 8,
  parameter int T_SHORT       = DEF_T_SHORT,
  parameter int T_MED         = DEF_T_MED,
  parameter int T_LONG        = DEF_T_LONG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             time_set,
  input  logic             s30,
  input  logic             s60,
  input  logic             s120,
  input  logic             start_count,
  input  logic             stop_count,
  output logic             timeout,
  output logic [CNT_W-1:0] remaining,
  output logic             running,
  output logic             paused
);

  timer_state_t     state;
  logic             go;
  logic             valid;
  logic             tick;
  logic             count_en;
  logic [CNT_W-1:0] load_val;

  assign valid    = sel_valid(time_set, s30, s60, s120);
  assign go       = start_count && !stop_count;
  assign count_en = go && ((state == RUNNING) || (state == PAUSED));

  always_comb begin
    load_val = CNT_W'(T_LONG);
    if (s30)      load_val = CNT_W'(T_SHORT);
    else if (s60) load_val = CNT_W'(T_MED);
  end

  oven_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (count_en),
    .clr  (go && (state == ARMED)),
    .tick (tick)
  );

  // The resume edge out of PAUSED counts like a running edge, so paused
  // cycles add exactly one cycle each to the total cook latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      timeout   <= 1'b0;
      running   <= 1'b0;
      paused    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            state     <= ARMED;
            remaining <= load_val;
          end
        end
        ARMED: begin
          if (!time_set) begin
            state     <= IDLE;
            remaining <= '0;
          end else if (go) begin
            state   <= RUNNING;
            running <= 1'b1;
          end else if (valid) begin
            remaining <= load_val;
          end
        end
        RUNNING, PAUSED: begin
          if (!go) begin
            state   <= PAUSED;
            running <= 1'b0;
            paused  <= 1'b1;
          end else if (tick && (remaining == CNT_W'(1))) begin
            state     <= DONE;
            remaining <= '0;
            timeout   <= 1'b1;
            running   <= 1'b0;
            paused    <= 1'b0;
          end else begin
            if (tick && (remaining != '0)) remaining <= remaining - 1'b1;
            state   <= RUNNING;
            running <= 1'b1;
            paused  <= 1'b0;
          end
        end
        DONE: begin
          if (!start_count) begin
            state     <= IDLE;
            remaining <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          running   <= 1'b0;
          paused    <= 1'b0;
        end
      endcase
    end
  end

endmodule
